// File: rtl/mem_stage.sv
// Memory pipeline stage: single-port synchronous RAM loads/stores with lane handling,
// misalignment checking, and a registered writeback packet toward the register file.
module mem_stage #(
  parameter int MEM_AW      = 30,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_next,
  input  logic [31:0]       i_result,
  input  logic [31:0]       i_wdata,
  input  logic              i_memen,
  input  logic              i_regen,
  input  logic [2:0]        i_memstrb,
  input  logic [4:0]        i_rd,
  input  logic [32:0]       i_pc,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              o_valid,
  input  logic              i_next,
  output logic [4:0]        o_rd,
  output logic [31:0]       o_wdata,
  output logic              o_regen,
  output logic              o_err,
  output logic [32:0]       o_pc
);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regen_q, regen_d;
  logic        err_q, err_d;
  logic [32:0] pc_q, pc_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic [2:0]  ld_strb_q, ld_strb_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [32:0] ld_pc_q, ld_pc_d;

  logic        accept, is_load, is_store, strb_bad, misalign, acc_err;
  logic [1:0]  lo;
  logic [31:0] ld_shift, ld_data;
  logic [15:0] ld_half;

  // Handshake: a packet moves when valid && ready on the same edge. Upstream ready
  // (o_next) is high only in IDLE with the output slot empty or draining; the output
  // packet (o_valid) holds every field stable until the edge where i_next is high.
  assign o_next   = (state_q == S_IDLE) && (!valid_q || i_next);
  assign accept   = i_valid && o_next && !rst;
  assign lo       = i_result[1:0];
  assign is_load  = i_memen && i_regen;
  assign is_store = i_memen && !i_regen;

  always_comb begin
    strb_bad = (i_memstrb == 3'b011) || (i_memstrb == 3'b110) ||
               (i_memstrb == 3'b111) || (is_store && i_memstrb[2]);
    misalign = CHECK_ALIGN &&
               (((i_memstrb[1:0] == 2'b01) && lo[0]) ||
                ((i_memstrb[1:0] == 2'b10) && (lo != 2'b00)));
    acc_err  = i_memen && (strb_bad || misalign);
  end

  always_comb begin
    m_en    = accept && i_memen && !acc_err;
    m_addr  = i_result[MEM_AW+1:2];
    m_we    = 4'b0000;
    m_wdata = i_wdata;
    case (i_memstrb[1:0])
      2'b00:   m_wdata = {4{i_wdata[7:0]}};
      2'b01:   m_wdata = {2{i_wdata[15:0]}};
      default: m_wdata = i_wdata;
    endcase
    if (m_en && is_store) begin
      case (i_memstrb[1:0])
        2'b00:   m_we = 4'b0001 << lo;
        2'b01:   m_we = lo[1] ? 4'b1100 : 4'b0011;
        default: m_we = 4'b1111;
      endcase
    end
  end

  // Lane select uses the byte offset latched at accept; the RAM returns the whole word.
  always_comb begin
    ld_shift = m_rdata >> {ld_lo_q, 3'b000};
    ld_half  = ld_lo_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (ld_strb_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = m_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q && !i_next;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    regen_d   = regen_q;
    err_d     = err_q;
    pc_d      = pc_q;
    ld_lo_d   = ld_lo_q;
    ld_strb_d = ld_strb_q;
    ld_rd_d   = ld_rd_q;
    ld_pc_d   = ld_pc_q;
    if (state_q == S_LOAD) begin
      state_d = S_IDLE;
      valid_d = 1'b1;
      rd_d    = ld_rd_q;
      wdata_d = ld_data;
      regen_d = (ld_rd_q != 5'd0);
      err_d   = 1'b0;
      pc_d    = ld_pc_q;
    end else if (accept) begin
      if (is_load && !acc_err) begin
        state_d   = S_LOAD;
        ld_lo_d   = lo;
        ld_strb_d = i_memstrb;
        ld_rd_d   = i_rd;
        ld_pc_d   = i_pc;
      end else begin
        valid_d = 1'b1;
        rd_d    = i_rd;
        wdata_d = i_result;
        regen_d = i_regen && !i_memen && (i_rd != 5'd0);
        err_d   = acc_err;
        pc_d    = i_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      rd_q      <= 5'd0;
      wdata_q   <= 32'd0;
      regen_q   <= 1'b0;
      err_q     <= 1'b0;
      pc_q      <= 33'd0;
      ld_lo_q   <= 2'd0;
      ld_strb_q <= 3'd0;
      ld_rd_q   <= 5'd0;
      ld_pc_q   <= 33'd0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      regen_q   <= regen_d;
      err_q     <= err_d;
      pc_q      <= pc_d;
      ld_lo_q   <= ld_lo_d;
      ld_strb_q <= ld_strb_d;
      ld_rd_q   <= ld_rd_d;
      ld_pc_q   <= ld_pc_d;
    end
  end

  assign o_valid = valid_q;
  assign o_rd    = rd_q;
  assign o_wdata = wdata_q;
  assign o_regen = regen_q;
  assign o_err   = err_q;
  assign o_pc    = pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single packets plus hand-written
// sequences for back-to-back flow, back-pressure and reset during a load.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_next, i_memen, i_regen, i_next;
  logic [31:0] i_result, i_wdata, m_wdata, o_wdata;
  logic [2:0]  i_memstrb;
  logic [4:0]  i_rd, o_rd;
  logic [32:0] i_pc, o_pc;
  logic        m_en, o_valid, o_regen, o_err;
  logic [3:0]  m_we;
  logic [29:0] m_addr;
  logic [31:0] m_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  mem_stage #(.MEM_AW(30), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_next(o_next),
    .i_result(i_result), .i_wdata(i_wdata), .i_memen(i_memen), .i_regen(i_regen),
    .i_memstrb(i_memstrb), .i_rd(i_rd), .i_pc(i_pc),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .o_valid(o_valid), .i_next(i_next), .o_rd(o_rd), .o_wdata(o_wdata),
    .o_regen(o_regen), .o_err(o_err), .o_pc(o_pc)
  );

  // Single-port synchronous RAM with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we == 4'b0000) m_rdata <= ram[m_addr[7:0]];
      else
        for (int b = 0; b < 4; b++)
          if (m_we[b]) ram[m_addr[7:0]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic [31:0] res, wd;
    logic        memen, regen;
    logic [2:0]  strb;
    logic [4:0]  rd;
    logic        lat2;
    logic        e_men;
    logic [3:0]  e_we;
    logic [31:0] e_mwd, e_wd;
    logic        e_regen, e_err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [31:0] res, wd, input logic memen, regen,
                              input logic [2:0] strb, input logic [4:0] rd,
                              input logic lat2, e_men, input logic [3:0] e_we,
                              input logic [31:0] e_mwd, e_wd, input logic e_regen, e_err);
    vec_t v;
    v.res = res; v.wd = wd; v.memen = memen; v.regen = regen; v.strb = strb; v.rd = rd;
    v.lat2 = lat2; v.e_men = e_men; v.e_we = e_we; v.e_mwd = e_mwd; v.e_wd = e_wd;
    v.e_regen = e_regen; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, wd, input logic memen, regen,
                       input logic [2:0] strb, input logic [4:0] rd, input logic [32:0] pc);
    i_valid = v; i_result = res; i_wdata = wd; i_memen = memen; i_regen = regen;
    i_memstrb = strb; i_rd = rd; i_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    logic [32:0] pc;
    v = tbl[i];
    pc = 33'h1_0000_0000 + 33'(i);
    drive(1'b1, v.res, v.wd, v.memen, v.regen, v.strb, v.rd, pc);
    #1;
    chk($sformatf("v%0d_next", i), 64'(o_next), 64'd1);
    chk($sformatf("v%0d_men", i), 64'(m_en), 64'(v.e_men));
    chk($sformatf("v%0d_mwe", i), 64'(m_we), 64'(v.e_we));
    if (v.e_men) chk($sformatf("v%0d_maddr", i), 64'(m_addr), 64'(v.res[31:2]));
    if (v.e_we != 4'b0000) chk($sformatf("v%0d_mwdata", i), 64'(m_wdata), 64'(v.e_mwd));
    tick();
    if (v.lat2) begin
      i_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_ld_valid", i), 64'(o_valid), 64'd0);
      chk($sformatf("v%0d_ld_next", i), 64'(o_next), 64'd0);
      chk($sformatf("v%0d_ld_men", i), 64'(m_en), 64'd0);
      tick();
    end
    chk($sformatf("v%0d_valid", i), 64'(o_valid), 64'd1);
    chk($sformatf("v%0d_wdata", i), 64'(o_wdata), 64'(v.e_wd));
    chk($sformatf("v%0d_regen", i), 64'(o_regen), 64'(v.e_regen));
    chk($sformatf("v%0d_err", i), 64'(o_err), 64'(v.e_err));
    chk($sformatf("v%0d_rd", i), 64'(o_rd), 64'(v.rd));
    chk($sformatf("v%0d_pc", i), 64'(o_pc), 64'(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hold_wd;
    //               res           wd           mem  reg  strb    rd   lat2 men  we       mwd           wd           regen err
    tbl[0]  = mk(32'h5,        32'h0,        0, 1, 3'b000, 5'd1,  0, 0, 4'b0000, 32'h0,        32'h5,        1, 0);
    tbl[1]  = mk(32'h100,      32'hDEADBEEF, 1, 0, 3'b010, 5'd0,  0, 1, 4'b1111, 32'hDEADBEEF, 32'h100,      0, 0);
    tbl[2]  = mk(32'h100,      32'h0,        1, 1, 3'b010, 5'd4,  1, 1, 4'b0000, 32'h0,        32'hDEADBEEF, 1, 0);
    tbl[3]  = mk(32'h103,      32'h80,       1, 0, 3'b000, 5'd0,  0, 1, 4'b1000, 32'h80808080, 32'h103,      0, 0);
    tbl[4]  = mk(32'h103,      32'h0,        1, 1, 3'b000, 5'd5,  1, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 1, 0);
    tbl[5]  = mk(32'h103,      32'h0,        1, 1, 3'b100, 5'd6,  1, 1, 4'b0000, 32'h0,        32'h00000080, 1, 0);
    tbl[6]  = mk(32'h102,      32'h12345678, 1, 0, 3'b001, 5'd0,  0, 1, 4'b1100, 32'h56785678, 32'h102,      0, 0);
    tbl[7]  = mk(32'h102,      32'h0,        1, 1, 3'b001, 5'd7,  1, 1, 4'b0000, 32'h0,        32'h00005678, 1, 0);
    tbl[8]  = mk(32'h100,      32'h0,        1, 1, 3'b101, 5'd8,  1, 1, 4'b0000, 32'h0,        32'h0000BEEF, 1, 0);
    tbl[9]  = mk(32'h100,      32'h0,        1, 1, 3'b001, 5'd9,  1, 1, 4'b0000, 32'h0,        32'hFFFFBEEF, 1, 0);
    tbl[10] = mk(32'h101,      32'h0,        1, 1, 3'b000, 5'd10, 1, 1, 4'b0000, 32'h0,        32'hFFFFFFBE, 1, 0);
    tbl[11] = mk(32'h101,      32'h0,        1, 1, 3'b001, 5'd11, 0, 0, 4'b0000, 32'h0,        32'h101,      0, 1);
    tbl[12] = mk(32'h100,      32'h0,        1, 1, 3'b011, 5'd12, 0, 0, 4'b0000, 32'h0,        32'h100,      0, 1);
    tbl[13] = mk(32'h102,      32'h11223344, 1, 0, 3'b010, 5'd0,  0, 0, 4'b0000, 32'h0,        32'h102,      0, 1);
    tbl[14] = mk(32'h104,      32'h11223344, 1, 0, 3'b100, 5'd0,  0, 0, 4'b0000, 32'h0,        32'h104,      0, 1);
    tbl[15] = mk(32'h9,        32'h0,        0, 1, 3'b000, 5'd0,  0, 0, 4'b0000, 32'h0,        32'h9,        0, 0);
    tbl[16] = mk(32'h55,       32'h0,        0, 0, 3'b000, 5'd3,  0, 0, 4'b0000, 32'h0,        32'h55,       0, 0);

    // Clock/reset
    rst = 1'b1; i_next = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 33'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_wdata", 64'(o_wdata), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_regen_err", 64'({o_regen, o_err, o_rd}), 64'd0);
    rst = 1'b0;

    // Back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(5 + i), 32'h0, 1'b0, 1'b1, 3'b000, 5'(1 + i), 33'(i));
      exp_q.push_back(32'(5 + i));
      #1;
      chk($sformatf("b2b%0d_next", i), 64'(o_next), 64'd1);
      tick();
      chk($sformatf("b2b%0d_valid", i), 64'(o_valid), 64'd1);
      chk($sformatf("b2b%0d_wdata", i), 64'(o_wdata), 64'(exp_q.pop_front()));
      chk($sformatf("b2b%0d_regen", i), 64'(o_regen), 64'd1);
    end
    i_valid = 1'b0;
    tick();
    chk("b2b_drain", 64'(o_valid), 64'd0);

    for (int i = 0; i < 17; i++) apply_vec(i);
    i_valid = 1'b0;
    tick();

    // Back-pressure on a completed load
    drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b1, 3'b010, 5'd13, 33'h2A);
    tick();
    i_valid = 1'b0; i_next = 1'b0;
    tick();
    chk("bp_valid", 64'(o_valid), 64'd1);
    chk("bp_wdata", 64'(o_wdata), 64'h5678BEEF);
    hold_wd = o_wdata;
    drive(1'b1, 32'h77, 32'h0, 1'b0, 1'b1, 3'b000, 5'd14, 33'h2B);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_next", c), 64'(o_next), 64'd0);
      chk($sformatf("bp%0d_men", c), 64'(m_en), 64'd0);
      tick();
      chk($sformatf("bp%0d_wdata", c), 64'(o_wdata), 64'(hold_wd));
      chk($sformatf("bp%0d_rd", c), 64'(o_rd), 64'd13);
      chk($sformatf("bp%0d_valid", c), 64'(o_valid), 64'd1);
    end
    i_next = 1'b1;
    #1;
    chk("bp_release_next", 64'(o_next), 64'd1);
    tick();
    chk("bp_new_wdata", 64'(o_wdata), 64'h77);
    chk("bp_new_rd", 64'(o_rd), 64'd14);
    chk("bp_new_valid", 64'(o_valid), 64'd1);
    i_valid = 1'b0;
    tick();
    chk("bp_drain", 64'(o_valid), 64'd0);

    // Reset while in LOAD
    drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b1, 3'b010, 5'd15, 33'h3C);
    tick();
    i_valid = 1'b0;
    #1;
    chk("rl_in_load_next", 64'(o_next), 64'd0);
    rst = 1'b1;
    i_valid = 1'b1;
    #1;
    chk("rl_valid", 64'(o_valid), 64'd0);
    chk("rl_idle_next", 64'(o_next), 64'd1);
    chk("rl_men_in_rst", 64'(m_en), 64'd0);
    tick();
    chk("rl_valid_after_edge", 64'(o_valid), 64'd0);
    rst = 1'b0;
    drive(1'b1, 32'h9, 32'h0, 1'b0, 1'b1, 3'b000, 5'd0, 33'h3D);
    #1;
    chk("rl_first_next", 64'(o_next), 64'd1);
    tick();
    chk("rl_alu_valid", 64'(o_valid), 64'd1);
    chk("rl_alu_regen", 64'(o_regen), 64'd0);
    chk("rl_alu_wdata", 64'(o_wdata), 64'h9);
    chk("rl_alu_pc", 64'(o_pc), 64'h3D);
    i_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
